mpmc11_state_machine: RTL and testbench

Main sequencing FSM of the mpmc11 multi-port memory controller. It takes one arbitrated request from the request FIFO and drives the DDR UI command/write-data handshakes for a burst of 1..16 strips (128-bit beats). It tracks returning read beats and pulses done when the request completes. Its state output feeds the controller's previous-state tracker and the port data-steering logic.

---
 rtl/mpmc11_pkg.sv | 9 +
 rtl/mpmc11_timeout_ctr.sv | 18 +
 rtl/mpmc11_state_machine.sv | 114 +++++++++++
 tb/tb_mpmc11_state_machine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared FSM state encoding and UI command codes for the mpmc11 controller
package mpmc11_pkg;
  typedef enum logic [2:0] {
    IDLE, PRESET1, PRESET2, WRITE_DATA0, WRITE_DONE, READ_DATA0, READ_DATA1, READ_DONE
  } mpmc11_state_t;
  localparam logic [2:0] CMD_WRITE   = 3'b000;
  localparam logic [2:0] CMD_READ    = 3'b001;
  localparam int         STRIP_BYTES = 16;
endpackage

// File: rtl/mpmc11_timeout_ctr.sv
// mpmc11_timeout_ctr: idle-cycle counter that flags the cycle on which the count reaches TIMEOUT
module mpmc11_timeout_ctr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = inc && !clr && cnt_q == W'(TIMEOUT - 1);
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != W'(TIMEOUT)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/mpmc11_state_machine.sv
// mpmc11_state_machine: sequences one request into a 1..16-strip burst of DDR UI commands and write/read beats
module mpmc11_state_machine import mpmc11_pkg::*; #(
  parameter int STRIP_BITS = 4,
  parameter int TIMEOUT    = 1023,
  parameter int ADR_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ui_rst,
  input  logic                  calib_complete,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADR_BITS-1:0]   req_adr,
  input  logic [STRIP_BITS-1:0] req_nstrips,
  output logic                  req_pop,
  input  logic                  app_rdy,
  input  logic                  app_wdf_rdy,
  input  logic                  rd_data_valid,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADR_BITS-1:0]   app_addr,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [STRIP_BITS-1:0] strip_cnt,
  output logic [STRIP_BITS-1:0] rd_beat_cnt,
  output mpmc11_state_t         state,
  output logic                  done,
  output logic                  timeout_err
);
  mpmc11_state_t         state_q, state_d;
  logic                  we_q, we_d, en_acc_q, en_acc_d, wd_acc_q, wd_acc_d;
  logic [ADR_BITS-1:0]   adr_q, adr_d, app_addr_q, app_addr_d;
  logic [STRIP_BITS-1:0] nstrips_q, nstrips_d, strip_cnt_q, strip_cnt_d, rd_beat_cnt_q, rd_beat_cnt_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic                  tmo_clr, tmo_inc, tmo_exp, en_done, wd_done, last_strip, last_beat;
  assign en_done    = en_acc_q | app_rdy;
  assign wd_done    = wd_acc_q | app_wdf_rdy;
  assign last_strip = strip_cnt_q == nstrips_q;
  assign last_beat  = rd_beat_cnt_q == nstrips_q;
  always_comb begin
    state_d = state_q; we_d = we_q; adr_d = adr_q; nstrips_d = nstrips_q;
    strip_cnt_d = strip_cnt_q; rd_beat_cnt_d = rd_beat_cnt_q; app_addr_d = app_addr_q;
    app_cmd_d = app_cmd_q; en_acc_d = en_acc_q; wd_acc_d = wd_acc_q;
    req_pop = 1'b0; tmo_clr = 1'b0; tmo_inc = 1'b0;
    case (state_q)
      IDLE: if (calib_complete && req_valid) begin
        req_pop = 1'b1; we_d = req_we; adr_d = req_adr; nstrips_d = req_nstrips; state_d = PRESET1;
      end
      PRESET1: begin
        strip_cnt_d = '0; rd_beat_cnt_d = '0; tmo_clr = 1'b1; app_addr_d = adr_q; state_d = PRESET2;
      end
      PRESET2: begin
        app_cmd_d = we_q ? CMD_WRITE : CMD_READ;
        state_d   = we_q ? WRITE_DATA0 : READ_DATA0;
      end
      WRITE_DATA0: if (en_done && wd_done) begin
        en_acc_d = 1'b0; wd_acc_d = 1'b0;
        if (last_strip) state_d = WRITE_DONE;
        else begin strip_cnt_d = strip_cnt_q + 1'b1; app_addr_d = app_addr_q + ADR_BITS'(STRIP_BYTES); end
      end else begin
        en_acc_d = en_done; wd_acc_d = wd_done;
      end
      READ_DATA0: begin
        if (app_rdy) begin
          if (last_strip) state_d = READ_DATA1;
          else begin strip_cnt_d = strip_cnt_q + 1'b1; app_addr_d = app_addr_q + ADR_BITS'(STRIP_BYTES); end
        end
        // beats can race ahead of the final command; count them without ever wrapping
        if (rd_data_valid) begin
          tmo_clr = 1'b1;
          if (!last_beat) rd_beat_cnt_d = rd_beat_cnt_q + 1'b1;
        end
      end
      READ_DATA1: if (rd_data_valid) begin
        tmo_clr = 1'b1;
        if (last_beat) state_d = READ_DONE;
        else rd_beat_cnt_d = rd_beat_cnt_q + 1'b1;
      end else begin
        tmo_inc = 1'b1;
        if (tmo_exp) state_d = READ_DONE;
      end
      WRITE_DONE, READ_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // UI reset abandons the burst: everything back to its reset value, nothing popped
    if (mem_ui_rst) begin
      state_d = IDLE; we_d = 1'b0; adr_d = '0; nstrips_d = '0; strip_cnt_d = '0; rd_beat_cnt_d = '0;
      app_addr_d = '0; app_cmd_d = '0; en_acc_d = 1'b0; wd_acc_d = 1'b0;
      req_pop = 1'b0; tmo_clr = 1'b1; tmo_inc = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE; we_q <= 1'b0; adr_q <= '0; nstrips_q <= '0; strip_cnt_q <= '0;
      rd_beat_cnt_q <= '0; app_addr_q <= '0; app_cmd_q <= '0; en_acc_q <= 1'b0; wd_acc_q <= 1'b0;
    end else begin
      state_q <= state_d; we_q <= we_d; adr_q <= adr_d; nstrips_q <= nstrips_d; strip_cnt_q <= strip_cnt_d;
      rd_beat_cnt_q <= rd_beat_cnt_d; app_addr_q <= app_addr_d; app_cmd_q <= app_cmd_d;
      en_acc_q <= en_acc_d; wd_acc_q <= wd_acc_d;
    end
  mpmc11_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(clk), .rst(rst), .clr(tmo_clr), .inc(tmo_inc), .expired(tmo_exp)
  );
  assign app_en       = (state_q == WRITE_DATA0 && !en_acc_q) || state_q == READ_DATA0;
  assign app_wdf_wren = state_q == WRITE_DATA0 && !wd_acc_q;
  assign app_wdf_end  = app_wdf_wren;
  assign app_cmd      = app_cmd_q;
  assign app_addr     = app_addr_q;
  assign strip_cnt    = strip_cnt_q;
  assign rd_beat_cnt  = rd_beat_cnt_q;
  assign state        = state_q;
  assign done         = state_q == WRITE_DONE || state_q == READ_DONE;
  assign timeout_err  = tmo_exp;
endmodule

// File: tb/tb_mpmc11_state_machine.sv
// tb_mpmc11_state_machine: scenario tasks with a command scoreboard for the mpmc11 sequencing FSM
module tb_mpmc11_state_machine;
  import mpmc11_pkg::*;
  localparam int SB = 4, TO = 1023, AB = 32;
  logic clk = 1'b0, rst = 1'b1, mem_ui_rst = 1'b0, calib_complete = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, app_rdy = 1'b0, app_wdf_rdy = 1'b0, rd_data_valid = 1'b0;
  logic [AB-1:0] req_adr = '0;
  logic [SB-1:0] req_nstrips = '0;
  logic req_pop, app_en, app_wdf_wren, app_wdf_end, done, timeout_err;
  logic [2:0] app_cmd;
  logic [AB-1:0] app_addr;
  logic [SB-1:0] strip_cnt, rd_beat_cnt;
  mpmc11_state_t state;
  int vectors = 0, miscompares = 0;
  int cyc = 0, pop_cnt = 0, pop_cyc = 0, done_cnt = 0, done_cyc = 0, tmo_cnt = 0, wd_cnt = 0;
  logic [AB+2:0] cmd_obs[$];
  logic [AB+2:0] exp_q[$];
  int rd_idx = 0;

  mpmc11_state_machine #(.STRIP_BITS(SB), .TIMEOUT(TO), .ADR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .mem_ui_rst(mem_ui_rst), .calib_complete(calib_complete),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr), .req_nstrips(req_nstrips),
    .req_pop(req_pop), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .rd_data_valid(rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .strip_cnt(strip_cnt), .rd_beat_cnt(rd_beat_cnt), .state(state),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (req_pop) begin pop_cnt <= pop_cnt + 1; pop_cyc <= cyc; end
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (timeout_err) tmo_cnt <= tmo_cnt + 1;
    if (app_wdf_wren && app_wdf_rdy) wd_cnt <= wd_cnt + 1;
    if (app_en && app_rdy) cmd_obs.push_back({app_cmd, app_addr});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_req(input logic we, input logic [AB-1:0] adr, input logic [SB-1:0] ns);
    bit got = 0;
    @(posedge clk); #1;
    req_we = we; req_adr = adr; req_nstrips = ns; req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (req_pop) got = 1; end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL req_pop_seen: got 0, required 1"); end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    bit got = 0;
    int p0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (state !== IDLE || app_en !== 1'b0 || app_wdf_wren !== 1'b0 || req_pop !== 1'b0 || done !== 1'b0 ||
        app_addr !== '0 || app_cmd !== 3'b000 || strip_cnt !== '0 || rd_beat_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d en=%b wren=%b addr=%h, required IDLE/0/0/0", state, app_en, app_wdf_wren, app_addr);
    end
    rst = 1'b0;
    issue_req(1'b1, 32'h3000, 4'd3);
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); if (state == WRITE_DATA0) got = 1; end
    vectors++;
    if (!got || app_en !== 1'b1 || app_wdf_wren !== 1'b1) begin
      miscompares++; $display("FAIL reset_reach_wd0: state=%0d en=%b, required WRITE_DATA0 en=1", state, app_en);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (state !== IDLE || app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_addr !== '0 || strip_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_async: state=%0d en=%b wren=%b addr=%h, required IDLE/0/0/0", state, app_en, app_wdf_wren, app_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (pop_cnt != p0 || state !== IDLE) begin
      miscompares++; $display("FAIL reset_no_pop: pops=%0d state=%0d, required 0 pops IDLE", pop_cnt - p0, state);
    end
  endtask

  task automatic test_write1;
    int d0 = done_cnt, w0 = wd_cnt;
    bit got = 0;
    logic [AB+2:0] e;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    exp_q.push_back({CMD_WRITE, 32'h1000});
    issue_req(1'b1, 32'h1000, 4'd0);
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); #1; if (done) got = 1; end
    vectors++;
    if (!got || done_cyc - pop_cyc != 4) begin
      miscompares++; $display("FAIL write1_latency: got %0d cycles (seen=%b), required 4", done_cyc - pop_cyc, got);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= cmd_obs.size()) begin miscompares++; $display("FAIL write1_cmd: missing, required %h", e); end
      else if (cmd_obs[rd_idx] !== e) begin miscompares++; $display("FAIL write1_cmd: got %h, required %h", cmd_obs[rd_idx], e); end
      rd_idx++;
    end
    vectors++;
    if (wd_cnt - w0 != 1) begin miscompares++; $display("FAIL write1_beats: got %0d, required 1", wd_cnt - w0); end
    @(negedge clk); #1;
    vectors++;
    if (state !== IDLE || done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL write1_end: state=%0d dones=%0d, required IDLE 1", state, done_cnt - d0);
    end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
  endtask

  task automatic test_write_split;
    int w0 = wd_cnt, age = 0, en_c = 0, wr_c = 0, split = 0, end_bad = 0;
    bit got = 0;
    logic [AB+2:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({CMD_WRITE, 32'h1000 + 32'(16 * i)});
    issue_req(1'b1, 32'h1000, 4'd3);
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge clk); #1;
      if (done) got = 1;
      else begin
        if (app_rdy) age = 0;
        age = app_en ? age + 1 : 0;
        app_rdy = app_en && age == 3;
        app_wdf_rdy = app_wdf_wren;
        if (app_en) en_c++;
        if (app_wdf_wren) wr_c++;
        if (app_en && !app_wdf_wren) split++;
        if (app_wdf_end !== app_wdf_wren) end_bad++;
      end
    end
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    vectors++;
    if (!got) begin miscompares++; $display("FAIL split_done: got 0, required 1"); end
    vectors++;
    if (en_c != 12 || wr_c != 4 || split != 8) begin
      miscompares++; $display("FAIL split_strobes: en=%0d wren=%0d en_only=%0d, required 12 4 8", en_c, wr_c, split);
    end
    vectors++;
    if (end_bad != 0) begin miscompares++; $display("FAIL split_wdf_end: got %0d bad cycles, required 0", end_bad); end
    @(negedge clk); #1;
    vectors++;
    if (wd_cnt - w0 != 4) begin miscompares++; $display("FAIL split_beats: got %0d, required 4", wd_cnt - w0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= cmd_obs.size()) begin miscompares++; $display("FAIL split_cmd: missing, required %h", e); end
      else if (cmd_obs[rd_idx] !== e) begin miscompares++; $display("FAIL split_cmd: got %h, required %h", cmd_obs[rd_idx], e); end
      rd_idx++;
    end
    vectors++;
    if (cmd_obs.size() != rd_idx) begin miscompares++; $display("FAIL split_extra_cmd: got %0d, required 0", cmd_obs.size() - rd_idx); end
  endtask

  task automatic test_read_early;
    int d0 = done_cnt, cmds = 0, beats = 0, early = 0;
    bit ph = 1, fin = 0;
    logic [AB+2:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({CMD_READ, 32'h2000 + 32'(16 * i)});
    issue_req(1'b0, 32'h2000, 4'd3);
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge clk); #1;
      if (app_rdy) cmds++;
      if (rd_data_valid) beats++;
      if (beats == 4) begin
        fin = 1;
        vectors++;
        if (state !== READ_DONE || done !== 1'b1) begin
          miscompares++; $display("FAIL read_done_after_4th: state=%0d done=%b, required READ_DONE 1", state, done);
        end
      end
      app_rdy = app_en && ph;
      if (app_en) ph = !ph;
      rd_data_valid = beats < cmds;
      if (rd_data_valid && !fin) begin
        vectors++;
        if (rd_beat_cnt !== SB'(beats)) begin
          miscompares++; $display("FAIL read_beat_idx: got %0d, required %0d", rd_beat_cnt, beats);
        end
        if (state == READ_DATA0) early++;
      end
    end
    app_rdy = 1'b0; rd_data_valid = 1'b0;
    vectors++;
    if (!fin || early == 0) begin miscompares++; $display("FAIL read_early: finished=%b early_beats=%0d, required 1 >0", fin, early); end
    @(posedge clk); #1;
    vectors++;
    if (state !== IDLE || done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL read_end: state=%0d dones=%0d, required IDLE 1", state, done_cnt - d0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_idx >= cmd_obs.size()) begin miscompares++; $display("FAIL read_cmd: missing, required %h", e); end
      else if (cmd_obs[rd_idx] !== e) begin miscompares++; $display("FAIL read_cmd: got %h, required %h", cmd_obs[rd_idx], e); end
      rd_idx++;
    end
  endtask

  task automatic test_timeout;
    int t0 = tmo_cnt, j = 1;
    bit got = 0, hit = 0;
    app_rdy = 1'b1;
    issue_req(1'b0, 32'h5000, 4'd3);
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; if (state == READ_DATA1) got = 1; end
    app_rdy = 1'b0;
    vectors++;
    if (!got) begin miscompares++; $display("FAIL tmo_reach_rd1: state=%0d, required READ_DATA1", state); end
    rd_data_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_data_valid = 1'b0;
    for (int i = 0; i < 1100 && !hit; i++) begin
      #1;
      if (timeout_err) hit = 1;
      else begin @(posedge clk); #1; j++; end
    end
    vectors++;
    if (!hit || j != TO) begin miscompares++; $display("FAIL tmo_cycles: got %0d (seen=%b), required %0d", j, hit, TO); end
    vectors++;
    if (rd_beat_cnt !== 4'd2 || done !== 1'b0) begin
      miscompares++; $display("FAIL tmo_beats: beat_cnt=%0d done=%b, required 2 0", rd_beat_cnt, done);
    end
    @(posedge clk); #1;
    vectors++;
    if (state !== READ_DONE || done !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL tmo_done: state=%0d done=%b err=%b, required READ_DONE 1 0", state, done, timeout_err);
    end
    @(posedge clk); #1;
    vectors++;
    if (state !== IDLE || tmo_cnt - t0 != 1) begin
      miscompares++; $display("FAIL tmo_idle: state=%0d err_pulses=%0d, required IDLE 1", state, tmo_cnt - t0);
    end
  endtask

  task automatic test_calib_uirst;
    int p0, d0;
    bit got = 0;
    calib_complete = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h4000; req_nstrips = 4'd1;
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (pop_cnt != p0 || state !== IDLE) begin
      miscompares++; $display("FAIL calib_gate: pops=%0d state=%0d, required 0 IDLE", pop_cnt - p0, state);
    end
    req_valid = 1'b0;
    calib_complete = 1'b1;
    app_rdy = 1'b1;
    issue_req(1'b0, 32'h4000, 4'd1);
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; if (state == READ_DATA1) got = 1; end
    app_rdy = 1'b0;
    vectors++;
    if (!got) begin miscompares++; $display("FAIL uirst_reach_rd1: state=%0d, required READ_DATA1", state); end
    d0 = done_cnt;
    mem_ui_rst = 1'b1;
    @(posedge clk); #1;
    mem_ui_rst = 1'b0;
    vectors++;
    if (state !== IDLE || strip_cnt !== '0 || app_addr !== '0 || app_cmd !== 3'b000 || done !== 1'b0) begin
      miscompares++; $display("FAIL uirst_idle: state=%0d addr=%h done=%b, required IDLE 0 0", state, app_addr, done);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt != d0) begin miscompares++; $display("FAIL uirst_no_done: got %0d dones, required 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset;
    test_write1;
    test_write_split;
    test_read_early;
    test_timeout;
    test_calib_uirst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
